cla_4bit: RTL and testbench

4-bit carry-lookahead adder slice with block propagate/generate outputs. It is the building block for wider adders in the Booth multiplier datapath of the FIR filter. A second-level lookahead unit combines several slices through `pg`/`gg`. The slice is either purely combinational or has a registered output stage, selected at compile time.

---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_lcu_4b.sv | 25 ++
 rtl/cla_4bit.sv | 76 +++++++
 tb/tb_cla_4bit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the 4-bit carry-lookahead slice and any wider
// lookahead units built from it.
package cla_pkg;

  localparam int CLA_W = 4;

  typedef logic [CLA_W-1:0] cla_word_t;

  // Bundle of every slice output, so the optional register stage is one flop group.
  typedef struct packed {
    cla_word_t s;
    logic      cout;
    logic      pg;
    logic      gg;
    logic      ovf;
  } cla_res_t;

  // Block generate of four propagate/generate pairs; reused by higher-level lookahead units.
  function automatic logic cla_gg(input cla_word_t p, input cla_word_t g);
    return g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_lcu_4b.sv
// Lookahead carry unit for one 4-bit group: flattened carry terms plus
// block propagate/generate for the next lookahead level.
module cla_lcu_4b
  import cla_pkg::*;
(
  input  cla_word_t  p,
  input  cla_word_t  g,
  input  logic       c0,
  output logic [4:1] c,
  output logic       pg,
  output logic       gg
);

  // Every carry is a two-level sum of products; no carry feeds another.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
    pg   = &p;
    gg   = cla_gg(p, g);
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = gg | (pg & c0);
  end

endmodule

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder slice with block propagate/generate outputs.
// Define CLA_4BIT_OUT_REG_EN to add a one-cycle output register stage;
// otherwise the slice is purely combinational and clk/rst_n are ignored.
module cla_4bit
  import cla_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  cla_word_t a,
  input  cla_word_t b,
  input  logic      cin,
  output cla_word_t s,
  output logic      cout,
  output logic      pg,
  output logic      gg,
  output logic      ovf
);

  cla_word_t  p;
  cla_word_t  g;
  logic [4:1] c;
  logic       lcu_pg;
  logic       lcu_gg;
  cla_res_t   res_d;

  cla_lcu_4b u_lcu (
    .p  (p),
    .g  (g),
    .c0 (cin),
    .c  (c),
    .pg (lcu_pg),
    .gg (lcu_gg)
  );

  // Bit-level propagate/generate, sum XORs and overflow around the carry unit.
  always_comb begin
    p          = a ^ b;
    g          = a & b;
    res_d.s    = p ^ {c[3:1], cin};
    res_d.cout = c[4];
    res_d.pg   = lcu_pg;
    res_d.gg   = lcu_gg;
    res_d.ovf  = c[3] ^ c[4];
  end

`ifdef CLA_4BIT_OUT_REG_EN
  cla_res_t res_q;

  // Output register: one-cycle latency, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign s    = res_q.s;
  assign cout = res_q.cout;
  assign pg   = res_q.pg;
  assign gg   = res_q.gg;
  assign ovf  = res_q.ovf;
`else
  // Clock and reset stay on the port list so instantiations match both builds.
  logic unused_clk_rst;
  assign unused_clk_rst = clk & rst_n;

  assign s    = res_d.s;
  assign cout = res_d.cout;
  assign pg   = res_d.pg;
  assign gg   = res_d.gg;
  assign ovf  = res_d.ovf;
`endif

endmodule

// File: tb/tb_cla_4bit.sv
// Scoreboard bench for cla_4bit. Works for both builds: the expected
// latency follows CLA_4BIT_OUT_REG_EN.
module tb_cla_4bit;

`ifdef CLA_4BIT_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;
  logic       pg;
  logic       gg;
  logic       ovf;

  cla_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .s     (s),
    .cout  (cout),
    .pg    (pg),
    .gg    (gg),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected response word: {s, cout, pg, gg, ovf}.
  typedef struct {
    logic [7:0] exp;
    int         due;
    string      name;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  int n_cmp;
  int n_err;
  initial begin
    n_cmp = 0;
    n_err = 0;
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {s,cout,pg,gg,ovf}=%h_%b%b%b%b expected %h_%b%b%b%b",
               name, got[7:4], got[3], got[2], got[1], got[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Arithmetic reference, independent of any lookahead formulation.
  function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    int         u;
    int         sv;
    logic [3:0] ms;
    logic       mpg;
    logic       mgg;
    logic       mov;
    u   = int'(ma) + int'(mb) + int'(mc);
    sv  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    ms  = u[3:0];
    mpg = ((ma ^ mb) == 4'hF);
    mgg = ((int'(ma) + int'(mb)) > 15);
    mov = (sv > 7) || (sv < -8);
    return {ms, u[4], mpg, mgg, mov};
  endfunction

  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic [7:0] exp, input string name);
    sb_entry_t e;
    a   = va;
    b   = vb;
    cin = vc;
    e.exp  = exp;
    e.due  = cyc + LAT;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: compares the head of the scoreboard when its result is due.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          check({e.name, "_missed"}, 8'hxx, e.exp);
        end else begin
          check(e.name, {s, cout, pg, gg, ovf}, e.exp);
        end
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_drain(input string name);
    int budget;
    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d results never checked, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{4'h0, 4'h0, 1'b0, {4'h0, 1'b0, 1'b0, 1'b0, 1'b0}, "zero"};
    vecs[1] = '{4'h7, 4'h7, 1'b1, {4'hF, 1'b0, 1'b0, 1'b0, 1'b1}, "7+7+1"};
    vecs[2] = '{4'h9, 4'h7, 1'b0, {4'h0, 1'b1, 1'b0, 1'b1, 1'b0}, "-7+7+0"};
    vecs[3] = '{4'h9, 4'h7, 1'b1, {4'h1, 1'b1, 1'b0, 1'b1, 1'b0}, "-7+7+1"};
    vecs[4] = '{4'h5, 4'hA, 1'b0, {4'hF, 1'b0, 1'b1, 1'b0, 1'b0}, "5+10+0"};
    vecs[5] = '{4'h5, 4'hA, 1'b1, {4'h0, 1'b1, 1'b1, 1'b0, 1'b0}, "5+10+1"};
    vecs[6] = '{4'hF, 4'hF, 1'b1, {4'hF, 1'b1, 1'b0, 1'b1, 1'b0}, "F+F+1"};
    vecs[7] = '{4'h8, 4'h8, 1'b0, {4'h0, 1'b1, 1'b0, 1'b1, 1'b1}, "-8+-8+0"};

    rst_n = 1'b0;
    a     = 4'h0;
    b     = 4'h0;
    cin   = 1'b0;
    #2;
    check("reset_state", {s, cout, pg, gg, ovf}, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors, one per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, vecs[i].name);
      @(posedge clk);
      #1;
    end
    wait_drain("directed_drain");

`ifdef CLA_4BIT_OUT_REG_EN
    // Reset between edges with 7+7+1 on the inputs: outputs clear at once,
    // the in-flight result is lost, and the first edge after release yields F.
    @(posedge clk);
    #1;
    a   = 4'h7;
    b   = 4'h7;
    cin = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", {s, cout, pg, gg, ovf}, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_edge", {s, cout, pg, gg, ovf}, 8'h00);
    rst_n = 1'b1;
    drive(4'h7, 4'h7, 1'b1, {4'hF, 1'b0, 1'b0, 1'b0, 1'b1}, "first_after_reset");
    @(posedge clk);
    #1;
    wait_drain("reset_drain");
`endif

    // Exhaustive sweep of a, b, cin against the arithmetic model.
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kv;
      kv = k[8:0];
      drive(kv[8:5], kv[4:1], kv[0], model(kv[8:5], kv[4:1], kv[0]), "sweep");
      @(posedge clk);
      #1;
    end
    wait_drain("sweep_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
